wbs_dma_csr_mc: RTL and testbench

Multi-channel Wishbone slave control/status register bank for the scatter-gather DMA engine, replacing the single-channel register slave. It provides per-channel CCR, NDAR and DAR access, plus three additions: a W1C interrupt status register with mask, a saturating descriptor-done counter, and byte-select writes. All slave responses are registered, and out-of-range accesses are rejected with wbs_err_o.

---
 rtl/wbs_dma_csr_mc.sv | 214 +++++++++++++++++++++
 tb/tb_wbs_dma_csr_mc.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/wbs_dma_csr_mc.sv
// wbs_dma_csr_mc: multi-channel Wishbone slave register bank for the
// scatter-gather DMA engine.
//
// Each channel owns a 0x40-byte window (adr[7:6] = channel, adr[5:2] = reg):
//   0 CCR  RW   bit0 resume, bit1 enable, bit2 int_ack
//   1 CSR  RO   bit0 int pending, bit1 busy
//   2 DAR  RO   current descriptor address (dar_i)
//   3 NDAR RW   next descriptor address [31:3]
//   4 ISR  W1C  bit0 done, bit1 fault, bit2 wr_reject
//   5 IMR  RW   bits[2:0]
//   6 DCNT RO   saturating descriptor-done counter; any write clears it
//
// Ports:
//   wb_clk_i, wb_rst_i             clock, synchronous active-high reset
//   wbs_*                          Wishbone slave, registered ack/err/data
//   dar_i, busy_i                  per-channel status from the engine
//   done_i, fault_i                per-channel event pulses
//   *_clear_i                      per-channel clear pulses from the engine
//   enable_o, resume_o, int_ack_o  per-channel CCR bits
//   ndar_dirty_o, ndar_o           NDAR written since last engine pickup
//   int_o                          registered OR of all (ISR & IMR)
module wbs_dma_csr_mc #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       wbs_cyc_i,
  input  logic                       wbs_stb_i,
  input  logic                       wbs_we_i,
  input  logic [3:0]                 wbs_sel_i,
  input  logic [31:0]                wbs_adr_i,
  input  logic [31:0]                wbs_dat_i,
  output logic [31:0]                wbs_dat_o,
  output logic                       wbs_ack_o,
  output logic                       wbs_err_o,
  output logic                       wbs_rty_o,
  input  logic [CHANNELS*32-1:0]     dar_i,
  input  logic [CHANNELS-1:0]        busy_i,
  input  logic [CHANNELS-1:0]        done_i,
  input  logic [CHANNELS-1:0]        fault_i,
  input  logic [CHANNELS-1:0]        ndar_dirty_clear_i,
  input  logic [CHANNELS-1:0]        int_ack_clear_i,
  input  logic [CHANNELS-1:0]        resume_clear_i,
  output logic [CHANNELS-1:0]        enable_o,
  output logic [CHANNELS-1:0]        resume_o,
  output logic [CHANNELS-1:0]        int_ack_o,
  output logic [CHANNELS-1:0]        ndar_dirty_o,
  output logic [CHANNELS*29-1:0]     ndar_o,
  output logic                       int_o
);

  localparam logic [3:0] R_CCR  = 4'd0;
  localparam logic [3:0] R_CSR  = 4'd1;
  localparam logic [3:0] R_DAR  = 4'd2;
  localparam logic [3:0] R_NDAR = 4'd3;
  localparam logic [3:0] R_ISR  = 4'd4;
  localparam logic [3:0] R_IMR  = 4'd5;
  localparam logic [3:0] R_DCNT = 4'd6;

  logic                            ack_q, ack_d, err_q, err_d, int_q, int_d;
  logic [31:0]                     dat_q, dat_d;
  logic [CHANNELS-1:0]             resume_q, resume_d, enable_q, enable_d;
  logic [CHANNELS-1:0]             int_ack_q, int_ack_d, dirty_q, dirty_d;
  logic [CHANNELS-1:0][28:0]       ndar_q, ndar_d;
  logic [CHANNELS-1:0][2:0]        isr_q, isr_d, imr_q, imr_d;
  logic [CHANNELS-1:0][CNT_W-1:0]  dcnt_q, dcnt_d;

  logic       req, bad, wr;
  logic [1:0] ch;
  logic [3:0] idx;
  logic       unused_adr;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[b*8 +: 8] = sel[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // A request is only accepted while no termination is being presented, so
  // a held strobe terminates every second cycle.
  assign req = wbs_cyc_i & wbs_stb_i & ~ack_q & ~err_q;
  assign ch  = wbs_adr_i[7:6];
  assign idx = wbs_adr_i[5:2];
  assign bad = (int'(ch) >= CHANNELS) || (idx > R_DCNT);
  // sel=0 is acked but has no write effect at all
  assign wr  = req & wbs_we_i & ~bad & (|wbs_sel_i);
  assign unused_adr = ^{wbs_adr_i[31:8], wbs_adr_i[1:0]};

  always_comb begin
    logic        wr_c;
    logic [2:0]  unused_ndar_lo;
    logic [31:0] rdata;
    wr_c           = 1'b0;
    unused_ndar_lo = '0;
    rdata          = '0;
    ack_d          = 1'b0;
    err_d          = 1'b0;
    dat_d          = '0;
    int_d          = 1'b0;
    resume_d       = resume_q;
    enable_d       = enable_q;
    int_ack_d      = int_ack_q;
    dirty_d        = dirty_q;
    ndar_d         = ndar_q;
    isr_d          = isr_q;
    imr_d          = imr_q;
    dcnt_d         = dcnt_q;

    for (int c = 0; c < CHANNELS; c++) begin
      int_d = int_d | (|(isr_q[c] & imr_q[c]));
      wr_c  = wr && (ch == 2'(c));

      // engine clear pulses first so a same-cycle bus write overrides them
      if (resume_clear_i[c])     resume_d[c]  = 1'b0;
      if (int_ack_clear_i[c])    int_ack_d[c] = 1'b0;
      if (ndar_dirty_clear_i[c]) dirty_d[c]   = 1'b0;

      if (wr_c && wbs_sel_i[0] && idx == R_CCR) begin
        resume_d[c]  = wbs_dat_i[0];
        enable_d[c]  = wbs_dat_i[1];
        int_ack_d[c] = wbs_dat_i[2];
      end

      // NDAR is frozen while the channel runs; the write is dropped instead
      if (wr_c && idx == R_NDAR && !enable_q[c]) begin
        {ndar_d[c], unused_ndar_lo} = lane_merge({ndar_q[c], 3'b000}, wbs_dat_i, wbs_sel_i);
        dirty_d[c] = 1'b1;
      end

      // W1C clear, then event sets so a coincident set wins
      if (wr_c && wbs_sel_i[0] && idx == R_ISR) isr_d[c] = isr_q[c] & ~wbs_dat_i[2:0];
      isr_d[c] = isr_d[c] | {wr_c && idx == R_NDAR && enable_q[c], fault_i[c], done_i[c]};

      if (wr_c && wbs_sel_i[0] && idx == R_IMR) imr_d[c] = wbs_dat_i[2:0];

      // clear then count, so a write coincident with done leaves 1
      if (wr_c && idx == R_DCNT) dcnt_d[c] = '0;
      if (done_i[c])             dcnt_d[c] = sat_inc(dcnt_d[c]);

      if (ch == 2'(c)) begin
        case (idx)
          R_CCR:   rdata = {29'b0, int_ack_q[c], enable_q[c], resume_q[c]};
          R_CSR:   rdata = {30'b0, busy_i[c], |(isr_q[c] & imr_q[c])};
          R_DAR:   rdata = dar_i[c*32 +: 32];
          R_NDAR:  rdata = {ndar_q[c], 3'b000};
          R_ISR:   rdata = {29'b0, isr_q[c]};
          R_IMR:   rdata = {29'b0, imr_q[c]};
          R_DCNT:  rdata = 32'(dcnt_q[c]);
          default: rdata = '0;
        endcase
      end
    end

    if (req) begin
      if (bad) begin
        err_d = 1'b1;
      end else begin
        ack_d = 1'b1;
        dat_d = rdata;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      int_q     <= 1'b0;
      dat_q     <= '0;
      resume_q  <= '0;
      enable_q  <= '0;
      int_ack_q <= '0;
      dirty_q   <= '0;
      ndar_q    <= '0;
      isr_q     <= '0;
      imr_q     <= '0;
      dcnt_q    <= '0;
    end else begin
      ack_q     <= ack_d;
      err_q     <= err_d;
      int_q     <= int_d;
      dat_q     <= dat_d;
      resume_q  <= resume_d;
      enable_q  <= enable_d;
      int_ack_q <= int_ack_d;
      dirty_q   <= dirty_d;
      ndar_q    <= ndar_d;
      isr_q     <= isr_d;
      imr_q     <= imr_d;
      dcnt_q    <= dcnt_d;
    end
  end

  assign wbs_dat_o    = dat_q;
  assign wbs_ack_o    = ack_q;
  assign wbs_err_o    = err_q;
  assign wbs_rty_o    = 1'b0;
  assign enable_o     = enable_q;
  assign resume_o     = resume_q;
  assign int_ack_o    = int_ack_q;
  assign ndar_dirty_o = dirty_q;
  assign ndar_o       = ndar_q;
  assign int_o        = int_q;

endmodule

// File: tb/tb_wbs_dma_csr_mc.sv
module tb_wbs_dma_csr_mc;

  logic        clk, rst, cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat, dat;
  logic        ack, err, rty, intr;
  logic [63:0] dar;
  logic [1:0]  busy, done, fault, dclr, iclr, rclr;
  logic [1:0]  enable, resume, intack, dirty;
  logic [57:0] ndar;

  logic [31:0] r_dat;
  logic        r_ack, r_err, r_int;
  int          vec, miss;

  wbs_dma_csr_mc #(.CHANNELS(2), .CNT_W(2)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_dat_o(dat),
    .wbs_ack_o(ack), .wbs_err_o(err), .wbs_rty_o(rty),
    .dar_i(dar), .busy_i(busy), .done_i(done), .fault_i(fault),
    .ndar_dirty_clear_i(dclr), .int_ack_clear_i(iclr), .resume_clear_i(rclr),
    .enable_o(enable), .resume_o(resume), .int_ack_o(intack),
    .ndar_dirty_o(dirty), .ndar_o(ndar), .int_o(intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // advance one rising edge, land 1 time unit after it, drop one-shot pulses
  task automatic step();
    @(posedge clk);
    #1;
    done = '0; fault = '0; dclr = '0; iclr = '0; rclr = '0;
  endtask

  // single access: request sampled on the first edge, termination captured
  // right after it, then one idle edge so the next request is accepted
  task automatic bus(input logic w, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
    step();
    r_ack = ack; r_err = err; r_dat = dat; r_int = intr;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    step();
  endtask

  initial begin
    vec = 0; miss = 0;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; wdat = '0;
    dar = {32'hCAFE0040, 32'hBEEF0000};
    busy = '0; done = '0; fault = '0; dclr = '0; iclr = '0; rclr = '0;
    repeat (3) step();
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_dat", dat, 0);
    chk("rst_int", intr, 0);
    chk("rst_enable", enable, 0);
    chk("rst_dirty", dirty, 0);
    chk("rst_ndar", ndar, 0);
    chk("rty", rty, 0);
    rst = 1'b0;
    step();

    // held strobe on ch0 CCR read
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h00; sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("held_ack", ack, (i % 2 == 0) ? 64'd1 : 64'd0);
      if (i == 0) chk("held_dat", dat, 0);
    end
    cyc = 1'b0; stb = 1'b0;
    step();

    // NDAR write ch1 with enable=0
    bus(1'b1, 32'h4C, 4'hF, 32'h12345678);
    chk("ndar_wr_ack", r_ack, 1);
    chk("ndar_wr_err", r_err, 0);
    chk("ndar_o_ch1", ndar[57:29], 29'h2468ACF);
    chk("ndar_dirty", dirty, 2'b10);
    bus(1'b0, 32'h4C, 4'hF, 32'h0);
    chk("ndar_rd", r_dat, 32'h12345678);
    dclr = 2'b10;
    step();
    chk("dirty_clr", dirty, 2'b00);
    // clear and lane-0 write together: write wins
    dclr = 2'b10;
    bus(1'b1, 32'h4C, 4'b0001, 32'h00000010);
    chk("dirty_wr_wins", dirty, 2'b10);
    bus(1'b0, 32'h4C, 4'hF, 32'h0);
    chk("ndar_lane0", r_dat, 32'h12345610);
    dclr = 2'b10;
    step();

    // enable ch1, rejected NDAR write
    bus(1'b1, 32'h40, 4'hF, 32'h2);
    chk("enable_ch1", enable, 2'b10);
    bus(1'b1, 32'h4C, 4'hF, 32'hFFFFFFF8);
    chk("rej_ack", r_ack, 1);
    chk("rej_err", r_err, 0);
    chk("rej_ndar", ndar[57:29], 29'h2468AC2);
    chk("rej_dirty", dirty, 2'b00);
    bus(1'b0, 32'h50, 4'hF, 32'h0);
    chk("rej_isr", r_dat, 32'h4);
    bus(1'b1, 32'h54, 4'hF, 32'h4);
    chk("imr_int_lag", r_int, 0);
    chk("imr_int_set", intr, 1);
    busy = 2'b10;
    bus(1'b0, 32'h44, 4'hF, 32'h0);
    chk("csr_ch1", r_dat, 32'h3);
    busy = 2'b00;
    bus(1'b0, 32'h48, 4'hF, 32'h0);
    chk("dar_ch1", r_dat, 32'hCAFE0040);
    bus(1'b1, 32'h50, 4'hF, 32'h4);
    chk("w1c_int_lag", r_int, 1);
    chk("w1c_int_clr", intr, 0);
    bus(1'b1, 32'h54, 4'hF, 32'h0);
    bus(1'b1, 32'h40, 4'hF, 32'h0);
    chk("disable_ch1", enable, 2'b00);

    // out-of-range accesses
    bus(1'b0, 32'h88, 4'hF, 32'h0);
    chk("err_ch2_err", r_err, 1);
    chk("err_ch2_ack", r_ack, 0);
    chk("err_ch2_dat", r_dat, 0);
    bus(1'b1, 32'h80, 4'hF, 32'h2);
    chk("err_wr_err", r_err, 1);
    chk("err_wr_noeff", enable, 2'b00);
    bus(1'b1, 32'hC0, 4'hF, 32'h7);
    chk("err_ch3", r_err, 1);
    chk("err_ch3_noeff", {resume, enable, intack}, 0);
    bus(1'b0, 32'h1C, 4'hF, 32'h0);
    chk("err_idx7_err", r_err, 1);
    chk("err_idx7_dat", r_dat, 0);

    // byte selects
    bus(1'b1, 32'h14, 4'b0010, 32'h0000AB00);
    chk("imr_lane1_ack", r_ack, 1);
    bus(1'b0, 32'h14, 4'hF, 32'h0);
    chk("imr_lane1", r_dat, 0);
    bus(1'b1, 32'h14, 4'b0001, 32'h1);
    bus(1'b0, 32'h14, 4'hF, 32'h0);
    chk("imr_lane0", r_dat, 32'h1);
    bus(1'b1, 32'h0C, 4'b0100, 32'hAABBCCDD);
    bus(1'b0, 32'h0C, 4'hF, 32'h0);
    chk("ndar_lane2", r_dat, 32'h00BB0000);
    dclr = 2'b01;
    step();
    bus(1'b1, 32'h0C, 4'b0000, 32'hFFFFFFFF);
    chk("sel0_ack", r_ack, 1);
    chk("sel0_dirty", dirty, 2'b00);
    bus(1'b0, 32'h0C, 4'hF, 32'h0);
    chk("sel0_ndar", r_dat, 32'h00BB0000);

    // CCR clear pulses
    bus(1'b1, 32'h00, 4'hF, 32'h7);
    chk("ccr7_resume", resume, 2'b01);
    chk("ccr7_intack", intack, 2'b01);
    rclr = 2'b01; iclr = 2'b01;
    step();
    chk("clr_resume", resume, 2'b00);
    chk("clr_intack", intack, 2'b00);
    chk("clr_enable", enable, 2'b01);
    rclr = 2'b01;
    bus(1'b1, 32'h00, 4'hF, 32'h5);
    chk("ccr_wr_wins", resume, 2'b01);
    bus(1'b0, 32'h00, 4'hF, 32'h0);
    chk("ccr_rd", r_dat, 32'h5);
    bus(1'b1, 32'h00, 4'hF, 32'h0);

    // DCNT on ch0 (CNT_W=2 saturates at 3)
    done = 2'b01; step();
    done = 2'b01; step();
    bus(1'b0, 32'h18, 4'hF, 32'h0);
    chk("dcnt_2", r_dat, 32'd2);
    done = 2'b01; step();
    bus(1'b0, 32'h18, 4'hF, 32'h0);
    chk("dcnt_3", r_dat, 32'd3);
    done = 2'b01; step();
    done = 2'b01; step();
    bus(1'b0, 32'h18, 4'hF, 32'h0);
    chk("dcnt_sat", r_dat, 32'd3);
    chk("int_done", intr, 1);
    done = 2'b01;
    bus(1'b1, 32'h18, 4'hF, 32'h0);
    bus(1'b0, 32'h18, 4'hF, 32'h0);
    chk("dcnt_wr_done", r_dat, 32'd1);
    bus(1'b1, 32'h18, 4'hF, 32'h0);
    bus(1'b0, 32'h18, 4'hF, 32'h0);
    chk("dcnt_clr", r_dat, 32'd0);

    // ISR W1C vs set
    bus(1'b0, 32'h10, 4'hF, 32'h0);
    chk("isr_done", r_dat, 32'h1);
    done = 2'b01;
    bus(1'b1, 32'h10, 4'hF, 32'h1);
    bus(1'b0, 32'h10, 4'hF, 32'h0);
    chk("isr_set_wins", r_dat, 32'h1);
    bus(1'b1, 32'h10, 4'hF, 32'h1);
    chk("isr_w1c_lag", r_int, 1);
    chk("isr_w1c_int", intr, 0);
    bus(1'b0, 32'h10, 4'hF, 32'h0);
    chk("isr_w1c", r_dat, 32'h0);
    fault = 2'b10;
    step();
    bus(1'b0, 32'h50, 4'hF, 32'h0);
    chk("isr_fault_ch1", r_dat, 32'h2);

    // reset in the middle of a request
    bus(1'b1, 32'h00, 4'hF, 32'h2);
    chk("pre_rst_en", enable, 2'b01);
    rst = 1'b1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h00; sel = 4'hF;
    step();
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_en", enable, 0);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    step();
    chk("post_rst_ack", ack, 0);
    bus(1'b0, 32'h50, 4'hF, 32'h0);
    chk("post_rst_isr", r_dat, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
